// File: rtl/axi_top.sv
// axi_top: register-mapped regex coprocessor with one backtracking engine.
// A shared word memory holds both the compiled program (one 16-bit
// instruction per word) and the little-endian byte string. Software writes
// code and data, issues START, then polls status and reads the cycle count.
//
// Ports:
//   clk                       in  1   clock, rising edge
//   rst                       in  1   asynchronous reset, active-high
//   data_in_register          in  32  write data for WRITE
//   address_register          in  32  word address for WRITE/READ (wraps)
//   start_cc_pointer_register in  32  byte address of the first string char
//   end_cc_pointer_register   in  32  byte address of the last char (inclusive)
//   cmd_register              in  32  NOP=0 WRITE=1 START=2 RESET=3 READ=4 READ_ELAPSED_CLOCK=5
//   status_register           out 32  IDLE=0 RUNNING=1 ACCEPTED=2 REJECTED=3 ERROR=4
//   data_o_register           out 32  combinational read data
//
// Build option: define AXI_TOP_SEARCH_EN for unanchored search (a failure
// with an empty stack retries from the next start byte). Without it the
// match is anchored at the start byte.
module axi_top #(
  parameter int BB_N        = 1,
  parameter int CC_ID_BITS  = 2,
  parameter int MEM_WORDS   = 1024,
  parameter int STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in_register,
  input  logic [31:0] address_register,
  input  logic [31:0] start_cc_pointer_register,
  input  logic [31:0] end_cc_pointer_register,
  input  logic [31:0] cmd_register,
  output logic [31:0] status_register,
  output logic [31:0] data_o_register
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = $clog2(STACK_DEPTH);

  localparam logic [31:0] CMD_WRITE   = 32'd1;
  localparam logic [31:0] CMD_START   = 32'd2;
  localparam logic [31:0] CMD_RESET   = 32'd3;
  localparam logic [31:0] CMD_READ    = 32'd4;
  localparam logic [31:0] CMD_ELAPSED = 32'd5;

  localparam logic [2:0] OP_ACCEPT     = 3'd0;
  localparam logic [2:0] OP_SPLIT      = 3'd1;
  localparam logic [2:0] OP_MATCH      = 3'd2;
  localparam logic [2:0] OP_NOTMATCH   = 3'd3;
  localparam logic [2:0] OP_ANY        = 3'd4;
  localparam logic [2:0] OP_JMP        = 3'd5;
  localparam logic [2:0] OP_ACCEPT_END = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_ACC  = 3'd2,
    ST_REJ  = 3'd3,
    ST_ERR  = 3'd4
  } status_e;

  // Only a single engine is implemented.
  if (BB_N != 1) begin : g_bb_n_check
    $error("axi_top: BB_N must be 1");
  end

  status_e          status_q, status_d;
  logic [31:0]      elapsed_q, elapsed_d;
  logic [31:0]      cc_q, cc_d;
  logic [31:0]      base_q, base_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;

  logic [31:0]      mem_q    [MEM_WORDS];
  logic [AW-1:0]    stk_pc_q [STACK_DEPTH];
  logic [31:0]      stk_cc_q [STACK_DEPTH];

  logic [15:0]      instr_s;
  logic [2:0]       op_s;
  logic [12:0]      arg_s;
  logic [31:0]      str_word_s;
  logic [7:0]       char_s;
  logic [32:0]      end_p1_s;
  logic             cc_in_s;
  logic             start_bad_s;
  logic             fail_s;
  logic             push_s;
  logic [SIW-1:0]   push_idx_s;
  logic [SIW-1:0]   top_idx_s;
  logic             unused_s;

  // Two combinational read ports: instruction at pc, string word at cc.
  assign instr_s    = mem_q[pc_q][15:0];
  assign op_s       = instr_s[15:13];
  assign arg_s      = instr_s[12:0];
  assign str_word_s = mem_q[cc_q[AW+1:2]];
  assign char_s     = str_word_s[{cc_q[1:0], 3'b000} +: 8];

  // end+1 is kept 33 bits wide so an end of 0xFFFFFFFF cannot wrap.
  assign end_p1_s    = {1'b0, end_cc_pointer_register} + 33'd1;
  assign cc_in_s     = (cc_q <= end_cc_pointer_register);
  assign start_bad_s = (start_cc_pointer_register[CC_ID_BITS-1:0] != '0) ||
                       ({1'b0, start_cc_pointer_register} > end_p1_s);

  assign push_idx_s = SIW'(sp_q);
  assign top_idx_s  = SIW'(sp_q - SPW'(1));

  assign status_register = {29'd0, status_q};

  assign unused_s = ^{address_register[31:AW], instr_s, str_word_s, mem_q[pc_q][31:16]};

  // Next-state logic: command handling and one instruction per RUNNING edge.
  always_comb begin
    status_d  = status_q;
    elapsed_d = elapsed_q;
    cc_d      = cc_q;
    base_d    = base_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    fail_s    = 1'b0;
    push_s    = 1'b0;

    if (cmd_register == CMD_RESET) begin
      status_d  = ST_IDLE;
      elapsed_d = 32'd0;
      cc_d      = 32'd0;
      base_d    = 32'd0;
      pc_d      = '0;
      sp_d      = '0;
    end else if (status_q != ST_RUN) begin
      if (cmd_register == CMD_START) begin
        if (start_bad_s) begin
          status_d = ST_ERR;
        end else begin
          status_d  = ST_RUN;
          pc_d      = '0;
          cc_d      = start_cc_pointer_register;
          base_d    = start_cc_pointer_register;
          elapsed_d = 32'd0;
          sp_d      = '0;
        end
      end else begin
        status_d = status_q;
      end
    end else begin
      elapsed_d = elapsed_q + 32'd1;
      case (op_s)
        OP_ACCEPT: status_d = ST_ACC;
        OP_SPLIT: begin
          if (sp_q == SPW'(STACK_DEPTH)) begin
            status_d = ST_ERR;
          end else begin
            push_s = 1'b1;
            sp_d   = sp_q + SPW'(1);
            pc_d   = pc_q + AW'(1);
          end
        end
        OP_MATCH: begin
          if (cc_in_s && (char_s == arg_s[7:0])) begin
            cc_d = cc_q + 32'd1;
            pc_d = pc_q + AW'(1);
          end else begin
            fail_s = 1'b1;
          end
        end
        OP_NOTMATCH: begin
          if (cc_in_s && (char_s != arg_s[7:0])) begin
            cc_d = cc_q + 32'd1;
            pc_d = pc_q + AW'(1);
          end else begin
            fail_s = 1'b1;
          end
        end
        OP_ANY: begin
          if (cc_in_s) begin
            cc_d = cc_q + 32'd1;
            pc_d = pc_q + AW'(1);
          end else begin
            fail_s = 1'b1;
          end
        end
        OP_JMP: pc_d = AW'(arg_s);
        OP_ACCEPT_END: begin
          if ({1'b0, cc_q} == end_p1_s) begin
            status_d = ST_ACC;
          end else begin
            fail_s = 1'b1;
          end
        end
        default: fail_s = 1'b1;
      endcase

      // Failure: backtrack if possible, otherwise retry or reject.
      if (fail_s) begin
        if (sp_q != '0) begin
          sp_d = sp_q - SPW'(1);
          pc_d = stk_pc_q[top_idx_s];
          cc_d = stk_cc_q[top_idx_s];
        end else begin
`ifdef AXI_TOP_SEARCH_EN
          if (base_q < end_cc_pointer_register) begin
            base_d = base_q + 32'd1;
            cc_d   = base_q + 32'd1;
            pc_d   = '0;
          end else begin
            status_d = ST_REJ;
          end
`else
          status_d = ST_REJ;
`endif
        end
      end else begin
        sp_d = sp_d;
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q  <= ST_IDLE;
      elapsed_q <= 32'd0;
      cc_q      <= 32'd0;
      base_q    <= 32'd0;
      pc_q      <= '0;
      sp_q      <= '0;
    end else begin
      status_q  <= status_d;
      elapsed_q <= elapsed_d;
      cc_q      <= cc_d;
      base_q    <= base_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
    end
  end

  // Backtrack stack storage; emptiness is tracked by sp_q alone.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stk_pc_q[push_idx_s] <= AW'(arg_s);
      stk_cc_q[push_idx_s] <= cc_q;
    end
  end

  // Shared memory write port; contents survive reset, writes blocked while running.
  always_ff @(posedge clk) begin
    if ((cmd_register == CMD_WRITE) && (status_q != ST_RUN)) begin
      mem_q[address_register[AW-1:0]] <= data_in_register;
    end
  end

  // Read data mux.
  always_comb begin
    data_o_register = 32'd0;
    case (cmd_register)
      CMD_ELAPSED: data_o_register = elapsed_q;
      CMD_READ:    data_o_register = mem_q[address_register[AW-1:0]];
      default:     data_o_register = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_axi_top.sv
module tb_axi_top;

  logic        clk;
  logic        rst;
  logic [31:0] data_in_register;
  logic [31:0] address_register;
  logic [31:0] start_cc_pointer_register;
  logic [31:0] end_cc_pointer_register;
  logic [31:0] cmd_register;
  logic [31:0] status_register;
  logic [31:0] data_o_register;

  int tests = 0;
  int fails = 0;

  axi_top dut (
    .clk                       (clk),
    .rst                       (rst),
    .data_in_register          (data_in_register),
    .address_register          (address_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .end_cc_pointer_register   (end_cc_pointer_register),
    .cmd_register              (cmd_register),
    .status_register           (status_register),
    .data_o_register           (data_o_register)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cmd_register     = 32'd1;
    address_register = a;
    data_in_register = d;
    step();
    cmd_register     = 32'd0;
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cmd_register     = 32'd4;
    address_register = a;
    #1;
    check(tag, data_o_register, exp);
    cmd_register     = 32'd0;
  endtask

  task automatic chk_elapsed(input string tag, input logic [31:0] exp);
    cmd_register = 32'd5;
    #1;
    check(tag, data_o_register, exp);
    cmd_register = 32'd0;
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] e);
    start_cc_pointer_register = s;
    end_cc_pointer_register   = e;
    cmd_register              = 32'd2;
    step();
    cmd_register              = 32'd0;
  endtask

  // Bounded wait for the engine to leave RUNNING; a timeout shows up as
  // a status mismatch in the following check.
  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (status_register != 32'd1) break;
      step();
    end
  endtask

  initial begin
    rst                       = 1'b1;
    data_in_register          = 32'd0;
    address_register          = 32'd0;
    start_cc_pointer_register = 32'd0;
    end_cc_pointer_register   = 32'd0;
    cmd_register              = 32'd0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("reset_status", status_register, 32'd0);
    check("nop_data_o", data_o_register, 32'd0);
    chk_elapsed("reset_elapsed", 32'd0);

    // MATCH 'a'; ACCEPT; "a" at byte 8
    wr(32'd0, 32'h0000_4061);
    wr(32'd1, 32'h0000_0000);
    wr(32'd2, 32'h0000_0061);
    chk_mem("read_w0", 32'd0, 32'h0000_4061);
    chk_mem("read_wrap", 32'd1026, 32'h0000_0061);

    start(32'd8, 32'd8);
    check("running_after_start", status_register, 32'd1);
    step();
    check("running_after_match", status_register, 32'd1);
    step();
    check("accepted_a", status_register, 32'd2);
    chk_elapsed("elapsed_a", 32'd2);
    step();
    step();
    step();
    check("accepted_held", status_register, 32'd2);
    chk_elapsed("elapsed_held", 32'd2);

    // Same program over "xab"
    wr(32'd2, 32'h0062_6178);
    start(32'd8, 32'd10);
    wait_done(50);
`ifdef AXI_TOP_SEARCH_EN
    check("xab_status", status_register, 32'd2);
    chk_elapsed("xab_elapsed", 32'd3);
`else
    check("xab_status", status_register, 32'd3);
    chk_elapsed("xab_elapsed", 32'd1);
`endif

    // Backtracking: SPLIT 3; MATCH 'b'; ACCEPT; MATCH 'a'; ACCEPT_END; "a" at byte 64
    wr(32'd0, 32'h0000_2003);
    wr(32'd1, 32'h0000_4062);
    wr(32'd2, 32'h0000_0000);
    wr(32'd3, 32'h0000_4061);
    wr(32'd4, 32'h0000_C000);
    wr(32'd16, 32'h0000_0061);
    start(32'd64, 32'd64);
    wait_done(50);
    check("backtrack_status", status_register, 32'd2);
    chk_elapsed("backtrack_elapsed", 32'd4);

    // Misaligned start
    start(32'd9, 32'd9);
    check("misaligned_error", status_register, 32'd4);
    chk_mem("misaligned_mem", 32'd0, 32'h0000_2003);

    // RESET command
    cmd_register = 32'd3;
    step();
    cmd_register = 32'd0;
    check("resetcmd_status", status_register, 32'd0);
    chk_elapsed("resetcmd_elapsed", 32'd0);
    chk_mem("resetcmd_mem", 32'd3, 32'h0000_4061);

    // 17 SPLIT 0 -> overflow on the 17th
    for (int i = 0; i < 17; i++) wr(i, 32'h0000_2000);
    start(32'd64, 32'd64);
    wait_done(50);
    check("overflow_status", status_register, 32'd4);
    chk_elapsed("overflow_elapsed", 32'd17);

    // MATCH 'a'; JMP 1 (spins forever after matching)
    wr(32'd0, 32'h0000_4061);
    wr(32'd1, 32'h0000_A001);
    wr(32'd16, 32'h0000_0061);

    // Empty string fails immediately; start beyond end+1 is an error
    start(32'd64, 32'd63);
    wait_done(50);
    check("empty_status", status_register, 32'd3);
    chk_elapsed("empty_elapsed", 32'd1);
    start(32'd68, 32'd63);
    check("start_past_end", status_register, 32'd4);

    // Long run, ignored START and WRITE, then async reset
    start(32'd64, 32'd64);
    for (int i = 0; i < 5; i++) step();
    check("loop_running", status_register, 32'd1);
    chk_elapsed("loop_elapsed5", 32'd5);
    start(32'd64, 32'd64);
    chk_elapsed("restart_ignored", 32'd6);
    wr(32'd5, 32'h0000_DEAD);
    check("write_while_running", status_register, 32'd1);
    cmd_register = 32'd5;
    rst = 1'b1;
    #1;
    check("rst_status", status_register, 32'd0);
    check("rst_elapsed", data_o_register, 32'd0);
    #2;
    rst = 1'b0;
    cmd_register = 32'd0;
    step();
    chk_mem("rst_mem_w0", 32'd0, 32'h0000_4061);
    chk_mem("rst_mem_w5", 32'd5, 32'h0000_2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
